// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between the fetch (F) and
// data (M) requesters. One transaction outstanding at a time, data has
// priority, in-flight fetches can be cancelled by a redirect, and a
// grant-to-response timeout raises a sticky bus error.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 64
) (
  input  logic                clk,
  input  logic                rst,
  // fetch requester
  input  logic                fetch_req,
  input  logic [ADDR_W-1:0]   fetch_addr,
  input  logic                fetch_flush,
  output logic [DATA_W-1:0]   fetch_rdata,
  output logic                fetch_valid,
  // data requester
  input  logic                data_req,
  input  logic                data_we,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W-1:0]   data_wdata,
  input  logic [DATA_W/8-1:0] data_be,
  output logic [DATA_W-1:0]   data_rdata,
  output logic                data_done,
  // memory port
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic                mem_gnt,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata,
  // pipeline control
  output logic                stall_f,
  output logic                stall_m,
  output logic                bus_err
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    DATA_WAIT  = 2'd1,
    FETCH_WAIT = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_drop;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_fetch_valid;
  logic               r_data_done;
  logic               r_bus_err;
  logic [DATA_W-1:0]  r_fetch_rdata;
  logic [DATA_W-1:0]  r_data_rdata;

  logic               w_data_act;
  logic               w_fetch_act;
  logic               w_timeout;
  logic               w_fetch_keep;

  // A requester is masked for the cycle its own completion pulse is visible,
  // since it has not yet had the chance to drop or change its request.
  assign w_data_act   = data_req & ~r_data_done;
  assign w_fetch_act  = fetch_req & ~fetch_flush & ~r_fetch_valid;
  // Last allowed wait cycle passed with no response.
  assign w_timeout    = (r_cnt == CNT_W'(TIMEOUT - 1)) & ~mem_rvalid;
  // A fetch response is delivered only if no redirect cancelled it.
  assign w_fetch_keep = ~r_drop & ~fetch_flush;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state and combinational memory request from the winning requester.
  always_comb begin
    w_state_nxt = r_state;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    mem_be      = '0;
    case (r_state)
      IDLE: begin
        if (w_data_act) begin
          mem_req   = 1'b1;
          mem_we    = data_we;
          mem_addr  = data_addr;
          mem_wdata = data_wdata;
          mem_be    = data_be;
          if (mem_gnt) w_state_nxt = DATA_WAIT;
        end else if (w_fetch_act) begin
          mem_req   = 1'b1;
          mem_addr  = fetch_addr;
          mem_be    = '1;
          if (mem_gnt) w_state_nxt = FETCH_WAIT;
        end
      end
      DATA_WAIT, FETCH_WAIT: begin
        if (mem_rvalid || w_timeout) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Response capture, completion pulses, drop flag, timeout counter, bus error.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_drop        <= 1'b0;
      r_cnt         <= '0;
      r_fetch_valid <= 1'b0;
      r_data_done   <= 1'b0;
      r_bus_err     <= 1'b0;
      r_fetch_rdata <= '0;
      r_data_rdata  <= '0;
    end else begin
      r_fetch_valid <= 1'b0;
      r_data_done   <= 1'b0;
      case (r_state)
        IDLE: begin
          if (mem_req && mem_gnt) r_cnt <= '0;
        end
        DATA_WAIT: begin
          if (mem_rvalid) begin
            r_data_rdata <= mem_rdata;
            r_data_done  <= 1'b1;
          end else if (w_timeout) begin
            r_data_rdata <= '0;
            r_data_done  <= 1'b1;
            r_bus_err    <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        FETCH_WAIT: begin
          if (mem_rvalid) begin
            if (w_fetch_keep) begin
              r_fetch_rdata <= mem_rdata;
              r_fetch_valid <= 1'b1;
            end
            r_drop <= 1'b0;
          end else if (w_timeout) begin
            if (w_fetch_keep) begin
              r_fetch_rdata <= '0;
              r_fetch_valid <= 1'b1;
            end
            r_drop    <= 1'b0;
            r_bus_err <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
            if (fetch_flush) r_drop <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign fetch_rdata = r_fetch_rdata;
  assign fetch_valid = r_fetch_valid;
  assign data_rdata  = r_data_rdata;
  assign data_done   = r_data_done;
  assign bus_err     = r_bus_err;
  assign stall_m     = data_req & ~r_data_done;
  assign stall_f     = (fetch_req & ~r_fetch_valid & ~fetch_flush) | stall_m;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed memory-side handshakes, expected
// completions queued at issue time and checked by an independent monitor.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst;
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic        fetch_flush;
  logic [31:0] fetch_rdata;
  logic        fetch_valid;
  logic        data_req;
  logic        data_we;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [3:0]  data_be;
  logic [31:0] data_rdata;
  logic        data_done;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        stall_f;
  logic        stall_m;
  logic        bus_err;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(64)) dut (
    .clk(clk), .rst(rst),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_flush(fetch_flush),
    .fetch_rdata(fetch_rdata), .fetch_valid(fetch_valid),
    .data_req(data_req), .data_we(data_we), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_be(data_be),
    .data_rdata(data_rdata), .data_done(data_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .stall_f(stall_f), .stall_m(stall_m), .bus_err(bus_err)
  );

  typedef struct {
    bit          is_data;
    logic [31:0] rdata;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input bit is_data, input logic [31:0] rdata);
    exp_t e;
    e.is_data = is_data;
    e.rdata   = rdata;
    sb.push_back(e);
  endtask

  // Monitor: every completion pulse must match the oldest expected response.
  always @(negedge clk) begin
    exp_t e;
    if (fetch_valid || data_done) begin
      checks++;
      if (fetch_valid && data_done) begin
        errors++;
        $display("FAIL dual_pulse fetch_valid=%0d data_done=%0d required one", fetch_valid, data_done);
      end else if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse fetch_valid=%0d data_done=%0d fetch_rdata=%h data_rdata=%h required none",
                 fetch_valid, data_done, fetch_rdata, data_rdata);
      end else begin
        e = sb.pop_front();
        if (e.is_data != data_done) begin
          errors++;
          $display("FAIL pulse_kind actual_data=%0d required_data=%0d", data_done, e.is_data);
        end else if (data_done && data_rdata !== e.rdata) begin
          errors++;
          $display("FAIL data_rdata actual=%h required=%h", data_rdata, e.rdata);
        end else if (fetch_valid && fetch_rdata !== e.rdata) begin
          errors++;
          $display("FAIL fetch_rdata actual=%h required=%h", fetch_rdata, e.rdata);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; fetch_req = 0; fetch_addr = 0; fetch_flush = 0;
    data_req = 0; data_we = 0; data_addr = 0; data_wdata = 0; data_be = 0;
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
    repeat (2) cyc();
    chk("rst_fetch_valid", fetch_valid, 0);
    chk("rst_data_done", data_done, 0);
    chk("rst_bus_err", bus_err, 0);
    chk("rst_fetch_rdata", fetch_rdata, 0);
    chk("rst_data_rdata", data_rdata, 0);
    chk("rst_mem_req", mem_req, 0);
    rst = 1'b0;

    // Fetch only, granted immediately, response two cycles later.
    cyc();
    fetch_req = 1; fetch_addr = 32'h100; mem_gnt = 1; #1;
    chk("f1_mem_req", mem_req, 1);
    chk("f1_mem_addr", mem_addr, 32'h100);
    chk("f1_mem_we", mem_we, 0);
    chk("f1_mem_be", mem_be, 4'hF);
    chk("f1_stall_f_c0", stall_f, 1);
    push(0, 32'h00500093);
    cyc();
    mem_gnt = 0; #1;
    chk("f1_mem_req_wait", mem_req, 0);
    chk("f1_stall_f_c1", stall_f, 1);
    cyc();
    mem_rvalid = 1; mem_rdata = 32'h00500093; #1;
    chk("f1_stall_f_c2", stall_f, 1);
    cyc();
    mem_rvalid = 0; #1;
    chk("f1_fetch_valid", fetch_valid, 1);
    chk("f1_stall_f_c3", stall_f, 0);
    chk("f1_masked_req", mem_req, 0);
    cyc();
    fetch_req = 0; #1;

    // Fetch and load together: load goes first, then the fetch.
    cyc();
    fetch_req = 1; fetch_addr = 32'h104;
    data_req = 1; data_we = 0; data_addr = 32'h2000; mem_gnt = 1; #1;
    chk("p_mem_addr", mem_addr, 32'h2000);
    chk("p_mem_we", mem_we, 0);
    chk("p_stall_m_c0", stall_m, 1);
    chk("p_stall_f_c0", stall_f, 1);
    push(1, 32'hDEADBEEF);
    cyc();
    mem_gnt = 0; #1;
    chk("p_mem_req_wait", mem_req, 0);
    chk("p_stall_m_c1", stall_m, 1);
    cyc();
    mem_rvalid = 1; mem_rdata = 32'hDEADBEEF; #1;
    chk("p_stall_m_c2", stall_m, 1);
    cyc();
    mem_rvalid = 0; #1;
    chk("p_data_done", data_done, 1);
    chk("p_stall_m_done", stall_m, 0);
    cyc();
    data_req = 0; mem_gnt = 1; #1;
    chk("p_fetch_req", mem_req, 1);
    chk("p_fetch_addr", mem_addr, 32'h104);
    push(0, 32'h00A00113);
    cyc();
    mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h00A00113; #1;
    cyc();
    mem_rvalid = 0; #1;
    chk("p_fetch_valid", fetch_valid, 1);
    cyc();
    fetch_req = 0; #1;

    // Partial store.
    cyc();
    data_req = 1; data_we = 1; data_addr = 32'h2004;
    data_wdata = 32'h12345678; data_be = 4'b0011; mem_gnt = 1; #1;
    chk("s_mem_we", mem_we, 1);
    chk("s_mem_be", mem_be, 4'b0011);
    chk("s_mem_addr", mem_addr, 32'h2004);
    chk("s_mem_wdata", mem_wdata, 32'h12345678);
    push(1, 32'hA5A5A5A5);
    cyc();
    mem_gnt = 0; #1;
    chk("s_data_done_early", data_done, 0);
    cyc();
    mem_rvalid = 1; mem_rdata = 32'hA5A5A5A5; #1;
    cyc();
    mem_rvalid = 0; #1;
    chk("s_data_done", data_done, 1);
    cyc();
    data_req = 0; data_we = 0; data_be = 0; data_wdata = 0; #1;
    chk("s_data_done_once", data_done, 0);

    // Redirect while a fetch is in flight.
    cyc();
    fetch_req = 1; fetch_addr = 32'h108; mem_gnt = 1; #1;
    cyc();
    mem_gnt = 0; fetch_flush = 1; #1;
    chk("fl_stall_f", stall_f, 0);
    chk("fl_mem_req", mem_req, 0);
    cyc();
    fetch_flush = 0; fetch_addr = 32'h200;
    mem_rvalid = 1; mem_rdata = 32'hBADBAD00; #1;
    cyc();
    mem_rvalid = 0; mem_gnt = 1; #1;
    chk("fl_no_valid", fetch_valid, 0);
    chk("fl_new_req", mem_req, 1);
    chk("fl_new_addr", mem_addr, 32'h200);
    push(0, 32'h00C00193);
    cyc();
    mem_gnt = 0; #1;
    cyc();
    mem_rvalid = 1; mem_rdata = 32'h00C00193; #1;
    cyc();
    mem_rvalid = 0; #1;
    chk("fl_new_valid", fetch_valid, 1);
    cyc();
    fetch_req = 0; #1;

    // Load with no response: timeout after 64 wait cycles.
    cyc();
    data_req = 1; data_we = 0; data_addr = 32'h3000; mem_gnt = 1; #1;
    chk("t_mem_addr", mem_addr, 32'h3000);
    push(1, 32'h0);
    for (int i = 1; i <= 64; i++) begin
      cyc();
      mem_gnt = 0; #1;
      if (i == 1) chk("t_mem_req_wait", mem_req, 0);
      if (i == 64) begin
        chk("t_bus_err_before", bus_err, 0);
        chk("t_done_before", data_done, 0);
      end
    end
    cyc();
    data_req = 0; #1;
    chk("t_data_done", data_done, 1);
    chk("t_bus_err", bus_err, 1);
    cyc();
    mem_rvalid = 1; mem_rdata = 32'h77777777; #1;
    cyc();
    mem_rvalid = 0; #1;
    chk("t_late_done", data_done, 0);
    chk("t_late_fvalid", fetch_valid, 0);
    chk("t_bus_err_sticky", bus_err, 1);

    // Reset while a load is in flight.
    cyc();
    data_req = 1; data_we = 0; data_addr = 32'h4000; mem_gnt = 1; #1;
    cyc();
    mem_gnt = 0; rst = 1; #1;
    cyc();
    rst = 0; data_req = 0; mem_rvalid = 1; mem_rdata = 32'h99999999; #1;
    chk("r_fetch_valid", fetch_valid, 0);
    chk("r_data_done", data_done, 0);
    chk("r_bus_err", bus_err, 0);
    chk("r_fetch_rdata", fetch_rdata, 0);
    chk("r_data_rdata", data_rdata, 0);
    chk("r_mem_req", mem_req, 0);
    chk("r_stall_m", stall_m, 0);
    chk("r_stall_f", stall_f, 0);
    cyc();
    mem_rvalid = 0; #1;
    chk("r_late_done", data_done, 0);
    chk("r_late_rdata", data_rdata, 0);

    repeat (3) cyc();
    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
